// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter sharing the register-file write port between two
// writeback requesters, plus a per-register pending-write busy scoreboard.
module rf_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_alloc_valid,
    input  logic [ADDR_W-1:0] i_alloc_rd,
    input  logic [ADDR_W-1:0] i_rs1,
    input  logic [ADDR_W-1:0] i_rs2,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy,
    input  logic              i_req0_valid,
    input  logic [ADDR_W-1:0] i_req0_rd,
    input  logic [DATA_W-1:0] i_req0_data,
    input  logic              i_req1_valid,
    input  logic [ADDR_W-1:0] i_req1_rd,
    input  logic [DATA_W-1:0] i_req1_data,
    output logic              o_req0_ready,
    output logic              o_req1_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_rd,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_idle,
    output logic              o_err
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [NREG-1:0] BIT0 = {{(NREG-1){1'b0}}, 1'b1};
    logic [NREG-1:0]   r_busy;
    logic              r_last_grant;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_rd;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_err;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_hs;
    logic [ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0] w_data;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_clr;
    logic [NREG-1:0]   w_busy_nxt;
    logic              w_waw;
    logic              w_unalloc;
    always_comb begin
        w_gnt0     = !i_reset && i_req0_valid && (!i_req1_valid || r_last_grant);
        w_gnt1     = !i_reset && i_req1_valid && (!i_req0_valid || !r_last_grant);
        w_hs       = w_gnt0 || w_gnt1;
        w_rd       = w_gnt1 ? i_req1_rd : i_req0_rd;
        w_data     = w_gnt1 ? i_req1_data : i_req0_data;
        w_set      = (i_alloc_valid && i_alloc_rd != '0) ? BIT0 << i_alloc_rd : '0;
        w_clr      = r_wr_en ? BIT0 << r_wr_rd : '0;
        // set is applied after clear so a same-index reallocation survives the retiring write
        w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~BIT0;
        w_waw      = i_alloc_valid && i_alloc_rd != '0 && r_busy[i_alloc_rd] &&
                     !(r_wr_en && r_wr_rd == i_alloc_rd);
        w_unalloc  = w_hs && w_rd != '0 && !r_busy[w_rd];
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy       <= '0;
            r_last_grant <= 1'b1;
            r_wr_en      <= 1'b0;
            r_wr_rd      <= '0;
            r_wr_data    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_wr_en <= w_hs && w_rd != '0;
            if (w_hs) begin
                r_last_grant <= w_gnt1;
                r_wr_rd      <= w_rd;
                r_wr_data    <= w_data;
            end
            if (w_waw || w_unalloc) r_err <= 1'b1;
        end
    end
    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;
    assign o_rs1_busy   = r_busy[i_rs1];
    assign o_rs2_busy   = r_busy[i_rs2];
    assign o_wr_en      = r_wr_en;
    assign o_wr_rd      = r_wr_rd;
    assign o_wr_data    = r_wr_data;
    assign o_err        = r_err;
    assign o_idle       = r_busy == '0 && !i_req0_valid && !i_req1_valid && !r_wr_en;
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port arbiter and pending-write scoreboard for the 32 x 32-bit register file. Two writeback requesters, port 0 for the ALU/short path and port 1 for the multi-cycle load/mul-div path, share the single register-file write port under round-robin arbitration. A busy bit per register lets issue logic stall on operands whose write is still in flight. Sits between the writeback units and the register file's write_enable/rd/rd_din inputs.

## Interface
- ADDR_W, 5, register index width (32 registers)
- DATA_W, 32, register data width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  issue marks alloc_rd as pending write this cycle
- alloc_rd  in  ADDR_W  destination register being allocated
- rs1, rs2  in  ADDR_W  lookup indices for operand hazard check
- rs1_busy, rs2_busy  out  1  combinational: registered busy bit of rs1/rs2
- req0_valid, req1_valid  in  1  writeback request from port 0/1
- req0_rd, req1_rd  in  ADDR_W  destination register of request
- req0_data, req1_data  in  DATA_W  write data of request
- req0_ready, req1_ready  out  1  combinational grant; handshake = valid && ready
- wr_en  out  1  registered write enable to register file
- wr_rd  out  ADDR_W  registered write index
- wr_data  out  DATA_W  registered write data
- idle  out  1  no busy bits set, no request valid, wr_en low
- err  out  1  sticky protocol-error flag

## Operation
- Clock is clk; reset is synchronous and active-high.
- State: busy[31:0], last_grant (1 bit), wr_en/wr_rd/wr_data registers, err.
- Reset: busy = 0, last_grant = 1 (port 0 wins first tie), wr_en = 0, wr_rd = 0, wr_data = 0, err = 0. req*_ready = 0 while reset is high.
- Arbitration, combinational:
  - only one valid: that port gets ready;
  - both valid: the port != last_grant gets ready, the other sees ready = 0 and must hold valid/rd/data stable;
  - neither valid: no ready.
- On a handshake: last_grant <= granted port; next cycle wr_en = (rd != 0), wr_rd = rd, wr_data = data. No handshake: wr_en <= 0 next cycle; wr_rd/wr_data hold.
- Busy update at each edge:
  - set busy[alloc_rd] if alloc_valid && alloc_rd != 0;
  - clear busy[wr_rd] if wr_en.
  - Clear and set of the same index in the same cycle: set wins.
- busy[0] is constant 0; alloc and requests to x0 never mark busy or write.
- Errors set err until reset:
  - alloc_valid to an index already busy and not cleared this cycle (WAW issue);
  - a handshake to a nonzero rd whose busy bit is 0 (unallocated write). The write is still performed.
- rs*_busy read registered busy only: no bypass of same-cycle alloc or clear.

## Timing
- Handshake in cycle T -> wr_en high during T+1 -> register file writes at end of T+1 -> busy clear visible and new value readable in T+2.
- Alloc in cycle T -> rsN_busy = 1 from T+1.
- Throughput: one write per cycle sustained; with both ports continuously valid, grants strictly alternate.
- Max wait for a valid requester: 1 cycle of the other port's grant.
- Reset mid-operation: a handshake in the reset cycle is discarded; wr_en is 0 in the cycle after reset and all busy bits clear.

## Test plan
- Reset, then alloc x5; next cycle rs1=5 -> rs1_busy=1. req0 rd=5 data=0xDEADBEEF handshakes at T -> wr_en=1, wr_rd=5, wr_data=0xDEADBEEF at T+1; rs1_busy=0 at T+2; err=0.
- Alloc x3 and x4; req0 (x3, 0x11) and req1 (x4, 0x22) both valid from the first cycle after reset -> port 0 granted first, port 1 next cycle; writes x3 then x4 on consecutive cycles.
- Both ports held valid for 6 cycles with fresh allocated rds -> grants alternate 0,1,0,1,0,1; no cycle without wr_en after the first.
- req1 rd=0 data=0x55 -> ready=1, wr_en stays 0, err=0; alloc rd=0 -> busy unchanged.
- Alloc x7 twice without an intervening write -> err=1 and stays 1. Separately, alloc x7 in the same cycle its wr_en clears it -> busy[7]=1, err=0.
- Assert reset while req0 handshakes and busy=0x000000F0 -> next cycle wr_en=0, busy=0, idle=1, err=0.
